// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings and the byte-lane decode used
// by the FPGA RAM adapter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Error response sequencing: OKAY, then a stalled and a completing ERROR cycle.
  typedef enum logic [1:0] {
    ERR_OKAY = 2'd0,
    ERR_1    = 2'd1,
    ERR_2    = 2'd2
  } err_state_e;

  // Byte-lane enables for a transfer; oversized transfers act as words.
  function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] mask;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_to_fpga_ram_wbuf.sv
// ahb_to_fpga_ram_wbuf: one-entry write buffer. Holds a write whose data
// phase met a read address phase, drains it on the next free RAM cycle and
// merges its bytes into read data while it is still pending.
module ahb_to_fpga_ram_wbuf
  import ahb_pkg::*;
#(
  parameter int WAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [WAW-1:0] load_addr,
  input  logic [3:0]     load_mask,
  input  logic [31:0]    load_data,
  input  logic           port_busy,
  input  logic           rd_dphase,
  input  logic [WAW-1:0] rd_addr,
  input  logic [31:0]    ram_rdata,
  output logic           drain,
  output logic           buf_valid,
  output logic [WAW-1:0] buf_addr,
  output logic [3:0]     buf_mask,
  output logic [31:0]    buf_data,
  output logic [31:0]    hrdata
);

  logic hit;

  // The buffer may use the RAM port only when nothing else owns it.
  assign drain = buf_valid & ~port_busy;
  assign hit   = buf_valid & (buf_addr == rd_addr);

  // Buffer occupancy: set on load, cleared once drained or on reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // Buffer payload, captured alongside the valid flag.
  // NOTE: payload registers carry no reset; buf_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_addr <= load_addr;
      buf_mask <= load_mask;
      buf_data <= load_data;
    end
  end

  // Read data: RAM output with pending buffered bytes substituted; zero outside a read data phase.
  // NOTE: the output gets a default before any branch so no latch is inferred.
  always_comb begin
    hrdata = '0;
    if (rd_dphase) begin
      for (int i = 0; i < 4; i++) begin
        hrdata[8*i +: 8] = (hit && buf_mask[i]) ? buf_data[8*i +: 8] : ram_rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_to_fpga_ram.sv
// ahb_to_fpga_ram: AHB-Lite slave adapter for a synchronous single-port FPGA
// block RAM. Reads and writes complete with zero wait states; a write data
// phase that collides with a read address phase is parked in a one-entry
// buffer. Define AHB_TO_RAM_ERR_EN to answer misaligned or oversized
// transfers with a two-cycle ERROR response instead of accessing the RAM.
module ahb_to_fpga_ram
  import ahb_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-3:0] RAM_ADDR,
  output logic [31:0]   RAM_WDATA,
  output logic [3:0]    RAM_WREN,
  output logic          RAM_CS,
  input  logic [31:0]   RAM_RDATA
);

  localparam int WAW = AW - 2;

  logic           addr_valid;
  logic           legal_ap;
  logic           rd_ap;
  logic           wr_ap;
  logic [WAW-1:0] ap_addr;
  logic [3:0]     ap_mask;
  logic           dph_valid;
  logic [WAW-1:0] dph_addr;
  logic [3:0]     dph_mask;
  logic           rd_dphase;
  logic [WAW-1:0] rd_addr;
  logic           drain;
  logic           buf_valid;
  logic [WAW-1:0] buf_addr;
  logic [3:0]     buf_mask;
  logic [31:0]    buf_data;
  logic [31:0]    merged_rdata;
  logic           unused_haddr;

  assign unused_haddr = &{1'b0, HADDR[31:AW]};
  assign addr_valid   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign ap_addr      = HADDR[AW-1:2];
  assign ap_mask      = byte_mask(HSIZE, HADDR[1:0]);

`ifdef AHB_TO_RAM_ERR_EN
  err_state_e err_state;
  err_state_e err_next;
  logic       illegal;
  logic       ready_out;
  logic       resp_err;

  // Flag misaligned halfwords/words and sizes wider than a word.
  always_comb begin
    illegal = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: illegal = 1'b0;
      HSIZE_HALF: illegal = HADDR[0];
      HSIZE_WORD: illegal = |HADDR[1:0];
      default:    illegal = 1'b1;
    endcase
  end

  assign legal_ap = addr_valid & ~illegal;

  // Error response state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_state <= ERR_OKAY;
    end else begin
      err_state <= err_next;
    end
  end

  // Error sequencing: the first ERROR cycle stalls the bus, the second completes it.
  always_comb begin
    err_next  = err_state;
    ready_out = 1'b1;
    resp_err  = 1'b0;
    case (err_state)
      ERR_OKAY: if (addr_valid && illegal) err_next = ERR_1;
      ERR_1: begin
        ready_out = 1'b0;
        resp_err  = 1'b1;
        err_next  = ERR_2;
      end
      ERR_2: begin
        resp_err = 1'b1;
        err_next = (addr_valid && illegal) ? ERR_1 : ERR_OKAY;
      end
      default: err_next = ERR_OKAY;
    endcase
  end

  assign HREADYOUT = RST | ready_out;
  assign HRESP     = ~RST & resp_err;
`else
  assign legal_ap  = addr_valid;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  assign rd_ap = legal_ap & ~HWRITE;
  assign wr_ap = legal_ap & HWRITE;

  // Control state of the pending write and read data phases.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dph_valid <= 1'b0;
      rd_dphase <= 1'b0;
    end else begin
      dph_valid <= wr_ap;
      rd_dphase <= rd_ap;
    end
  end

  // Address and lane information carried from address phase into data phase.
  always_ff @(posedge CLK) begin
    if (wr_ap) begin
      dph_addr <= ap_addr;
      dph_mask <= ap_mask;
    end
    if (rd_ap) begin
      rd_addr <= ap_addr;
    end
  end

  ahb_to_fpga_ram_wbuf #(
    .WAW(WAW)
  ) u_wbuf (
    .clk       (CLK),
    .rst       (RST),
    .load      (dph_valid & rd_ap),
    .load_addr (dph_addr),
    .load_mask (dph_mask),
    .load_data (HWDATA),
    .port_busy (rd_ap | dph_valid),
    .rd_dphase (rd_dphase),
    .rd_addr   (rd_addr),
    .ram_rdata (RAM_RDATA),
    .drain     (drain),
    .buf_valid (buf_valid),
    .buf_addr  (buf_addr),
    .buf_mask  (buf_mask),
    .buf_data  (buf_data),
    .hrdata    (merged_rdata)
  );

  // RAM port arbitration: read address phase, then direct write, then buffer drain.
  always_comb begin
    RAM_CS    = 1'b0;
    RAM_WREN  = 4'b0000;
    RAM_ADDR  = ap_addr;
    RAM_WDATA = HWDATA;
    if (rd_ap) begin
      RAM_CS = 1'b1;
    end else if (dph_valid) begin
      RAM_CS   = 1'b1;
      RAM_ADDR = dph_addr;
      RAM_WREN = dph_mask;
    end else if (drain) begin
      RAM_CS    = 1'b1;
      RAM_ADDR  = buf_addr;
      RAM_WREN  = buf_mask;
      RAM_WDATA = buf_data;
    end
    if (RST) begin
      RAM_CS   = 1'b0;
      RAM_WREN = 4'b0000;
    end
  end

  assign HRDATA = RST ? 32'h0 : merged_rdata;

endmodule

// File: tb/tb_ahb_to_fpga_ram.sv
// tb_ahb_to_fpga_ram: drives AHB transfers into ahb_to_fpga_ram attached to a
// behavioural block RAM, and checks bus responses and RAM strobes against a
// flat word-array memory model updated at transfer level.
module tb_ahb_to_fpga_ram;

  localparam int AW    = 14;
  localparam int WORDS = 1 << (AW - 2);

  logic          CLK = 1'b0;
  logic          RST;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-3:0] RAM_ADDR;
  logic [31:0]   RAM_WDATA;
  logic [3:0]    RAM_WREN;
  logic          RAM_CS;
  logic [31:0]   RAM_RDATA = '0;

  always #5 CLK = ~CLK;
  assign HREADY = HREADYOUT;

  ahb_to_fpga_ram #(.AW(AW)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WREN(RAM_WREN),
    .RAM_CS(RAM_CS), .RAM_RDATA(RAM_RDATA)
  );

  // Behavioural synchronous block RAM with a bench-side preload port.
  logic [31:0]   ram [WORDS];
  logic          poke_en = 1'b0;
  logic [AW-3:0] poke_addr = '0;
  logic [31:0]   poke_data = '0;
  int            ram_writes = 0;

  always @(posedge CLK) begin
    if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (RAM_CS) begin
      RAM_RDATA <= ram[RAM_ADDR];
      for (int i = 0; i < 4; i++)
        if (RAM_WREN[i]) ram[RAM_ADDR][8*i +: 8] <= RAM_WDATA[8*i +: 8];
      if (|RAM_WREN) ram_writes <= ram_writes + 1;
    end
  end

  // Reference memory: every write lands the moment it is issued.
  logic [31:0] model [WORDS];

  int n_cmp = 0;
  int n_bad = 0;

  // Pending data phases and per-cycle observations.
  logic          dp_write = 1'b0, dp_read = 1'b0;
  logic [31:0]   dp_wdata = '0, dp_exp = '0;
  logic          obs_rd, obs_ready, obs_resp, obs_cs, obs_overlap;
  logic [31:0]   obs_exp, obs_hrdata, obs_wdata;
  logic [3:0]    obs_wren;
  logic [AW-3:0] obs_addr;

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    int nbytes;
    int first;
    nbytes = 1 << size;
    first  = int'(addr[1:0]) & ~(nbytes - 1);
    for (int b = first; b < first + nbytes; b++)
      model[addr[AW-1:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic poke(input logic [AW-3:0] w, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = w; poke_data = d;
    model[w] = d;
    @(posedge CLK); #1;
    poke_en = 1'b0;
  endtask

  // One bus cycle: new address phase plus data for the previous one; captures observations.
  task automatic bus_cycle(input logic act, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata);
    HSEL = act; HTRANS = act ? 2'b10 : 2'b00; HADDR = addr; HSIZE = size; HWRITE = wr;
    HWDATA = dp_write ? dp_wdata : $urandom;
    @(negedge CLK);
    obs_rd = dp_read; obs_exp = dp_exp; obs_hrdata = HRDATA;
    obs_ready = HREADYOUT; obs_resp = HRESP;
    obs_cs = RAM_CS; obs_wren = RAM_WREN; obs_addr = RAM_ADDR; obs_wdata = RAM_WDATA;
    obs_overlap = dut.dph_valid & dut.u_wbuf.buf_valid;
    dp_write = act & wr; dp_wdata = wdata; dp_read = act & ~wr;
    if (act && wr) model_write(addr, size, wdata);
    if (act && !wr) dp_exp = model[addr[AW-1:2]];
    @(posedge CLK); #1;
  endtask

  task automatic idle;
    bus_cycle(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic test_reset;
    RST = 1'b1; HSEL = 0; HTRANS = 0; HADDR = 0; HSIZE = 0; HWRITE = 0; HWDATA = 0;
    @(posedge CLK); #1;
    for (int w = 'h40; w < 'h50; w++) poke(w[AW-3:0], $urandom);
    poke(12'h080, $urandom);
    poke(12'h0C0, $urandom);
    @(negedge CLK);
    n_cmp++;
    if ({RAM_CS, RAM_WREN, HREADYOUT, HRESP, HRDATA} !== {1'b0, 4'h0, 1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_hold: cs=%b wren=%h rdy=%b resp=%b rdata=%h, want 0 0 1 0 0",
               RAM_CS, RAM_WREN, HREADYOUT, HRESP, HRDATA);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    idle();
    n_cmp++;
    if ({obs_cs, obs_wren, obs_ready, obs_resp, obs_hrdata} !== {1'b0, 4'h0, 1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_values: cs=%b wren=%h rdy=%b resp=%b rdata=%h, want 0 0 1 0 0",
               obs_cs, obs_wren, obs_ready, obs_resp, obs_hrdata);
    end
  endtask

  task automatic test_direct_write;
    bus_cycle(1'b1, 1'b1, 32'h100, 3'd2, 32'hA5A5A5A5);
    idle();
    n_cmp++;
    if ({obs_cs, obs_wren, obs_addr, obs_wdata} !== {1'b1, 4'hF, 12'h040, 32'hA5A5A5A5}) begin
      n_bad++;
      $display("FAIL direct_write: cs=%b wren=%h addr=%h wdata=%h, want 1 f 040 a5a5a5a5",
               obs_cs, obs_wren, obs_addr, obs_wdata);
    end
    idle();
  endtask

  task automatic test_merge_word;
    bus_cycle(1'b1, 1'b1, 32'h100, 3'd2, 32'h11223344);
    bus_cycle(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
    n_cmp++;
    if ({obs_cs, obs_wren, obs_addr} !== {1'b1, 4'h0, 12'h040}) begin
      n_bad++;
      $display("FAIL merge_read_ap: cs=%b wren=%h addr=%h, want 1 0 040", obs_cs, obs_wren, obs_addr);
    end
    idle();
    n_cmp++;
    if (obs_hrdata !== 32'h11223344) begin
      n_bad++;
      $display("FAIL merge_word_data: got %h want 11223344", obs_hrdata);
    end
    n_cmp++;
    if ({obs_cs, obs_wren, obs_addr, obs_wdata} !== {1'b1, 4'hF, 12'h040, 32'h11223344}) begin
      n_bad++;
      $display("FAIL merge_word_drain: cs=%b wren=%h addr=%h wdata=%h, want 1 f 040 11223344",
               obs_cs, obs_wren, obs_addr, obs_wdata);
    end
    idle();
  endtask

  task automatic test_merge_byte;
    poke(12'h041, 32'hFFFFFFFF);
    bus_cycle(1'b1, 1'b1, 32'h105, 3'd0, 32'h0000AB00);
    bus_cycle(1'b1, 1'b0, 32'h104, 3'd2, 32'h0);
    idle();
    n_cmp++;
    if (obs_hrdata !== 32'hFFFFABFF) begin
      n_bad++;
      $display("FAIL merge_byte_data: got %h want ffffabff", obs_hrdata);
    end
    n_cmp++;
    if ({obs_cs, obs_wren, obs_addr} !== {1'b1, 4'b0010, 12'h041}) begin
      n_bad++;
      $display("FAIL merge_byte_drain: cs=%b wren=%b addr=%h, want 1 0010 041", obs_cs, obs_wren, obs_addr);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    logic [31:0] got [$];
    bus_cycle(1'b1, 1'b0, 32'h108, 3'd2, 32'h0);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: bus_cycle(1'b1, 1'b1, 32'h10C, 3'd2, 32'hCAFE0001);
        1: bus_cycle(1'b1, 1'b0, 32'h110, 3'd2, 32'h0);
        2: bus_cycle(1'b1, 1'b0, 32'h10C, 3'd2, 32'h0);
        3: bus_cycle(1'b1, 1'b0, 32'h10C, 3'd1, 32'h0);
        default: idle();
      endcase
      n_cmp++;
      if ({obs_ready, obs_resp, obs_overlap} !== 3'b100) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: rdy=%b resp=%b overlap=%b, want 1 0 0", c, obs_ready, obs_resp, obs_overlap);
      end
      if (obs_rd) begin
        got.push_back(obs_hrdata);
        n_cmp++;
        if (obs_hrdata !== obs_exp) begin
          n_bad++;
          $display("FAIL b2b_read%0d: got %h want %h", c, obs_hrdata, obs_exp);
        end
      end
    end
    n_cmp++;
    if (got.size() != 4 || got[2] !== 32'hCAFE0001 || got[3] !== 32'hCAFE0001) begin
      n_bad++;
      $display("FAIL b2b_pending_merge: reads=%0d, want 4 with last two cafe0001", got.size());
    end
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [2:0]  size;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      size = 3'($urandom_range(0, 2));
      addr = ($urandom() << AW) | (32'h100 + 32'($urandom_range(0, 15)) * 4);
      addr[1:0] = 2'($urandom_range(0, 3)) & ~2'((1 << size) - 1);
      if (kind == 0) idle();
      else bus_cycle(1'b1, kind >= 2, addr, size, $urandom);
      n_cmp++;
      if ({obs_ready, obs_resp, obs_overlap} !== 3'b100) begin
        n_bad++;
        $display("FAIL rand_status%0d: rdy=%b resp=%b overlap=%b, want 1 0 0", n, obs_ready, obs_resp, obs_overlap);
      end
      n_cmp++;
      if (obs_hrdata !== (obs_rd ? obs_exp : 32'h0)) begin
        n_bad++;
        $display("FAIL rand_rdata%0d: got %h want %h", n, obs_hrdata, obs_rd ? obs_exp : 32'h0);
      end
    end
    idle();
    idle();
    n_cmp++;
    if ({obs_cs, obs_wren} !== 5'b0) begin
      n_bad++;
      $display("FAIL rand_quiet: cs=%b wren=%h, want 0 0", obs_cs, obs_wren);
    end
    for (int w = 'h40; w < 'h50; w++) begin
      n_cmp++;
      if (ram[w] !== model[w]) begin
        n_bad++;
        $display("FAIL rand_ram_word%0h: got %h want %h", w, ram[w], model[w]);
      end
    end
  endtask

`ifdef AHB_TO_RAM_ERR_EN
  task automatic test_error;
    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h102; HSIZE = 3'd2; HWRITE = 0; HWDATA = $urandom;
    @(negedge CLK);
    n_cmp++;
    if ({RAM_CS, HREADYOUT, HRESP} !== 3'b010) begin
      n_bad++;
      $display("FAIL err_aphase: cs=%b rdy=%b resp=%b, want 0 1 0", RAM_CS, HREADYOUT, HRESP);
    end
    @(posedge CLK); #1;
    HSEL = 0; HTRANS = 2'b00;
    @(negedge CLK);
    n_cmp++;
    if ({HREADYOUT, HRESP} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_cycle1: rdy=%b resp=%b, want 0 1", HREADYOUT, HRESP);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++;
    if ({HREADYOUT, HRESP} !== 2'b11) begin
      n_bad++;
      $display("FAIL err_cycle2: rdy=%b resp=%b, want 1 1", HREADYOUT, HRESP);
    end
    @(posedge CLK); #1;
    bus_cycle(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
    idle();
    n_cmp++;
    if ({obs_ready, obs_resp, obs_hrdata} !== {1'b1, 1'b0, model[12'h040]}) begin
      n_bad++;
      $display("FAIL err_recover: rdy=%b resp=%b rdata=%h, want 1 0 %h", obs_ready, obs_resp, obs_hrdata, model[12'h040]);
    end
  endtask
`endif

  task automatic test_reset_discard;
    logic [31:0] old_word;
    int          writes_before;
    old_word = ram[12'h080];
    bus_cycle(1'b1, 1'b1, 32'h200, 3'd2, ~old_word);
    bus_cycle(1'b1, 1'b0, 32'h300, 3'd2, 32'h0);
    writes_before = ram_writes;
    RST = 1'b1; HSEL = 0; HTRANS = 0;
    @(negedge CLK);
    n_cmp++;
    if ({RAM_CS, RAM_WREN} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_mid_strobes: cs=%b wren=%h, want 0 0", RAM_CS, RAM_WREN);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    dp_write = 1'b0; dp_read = 1'b0;
    for (int c = 0; c < 3; c++) idle();
    n_cmp++;
    if ({obs_hrdata, obs_ready} !== {32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_mid_bus: rdata=%h rdy=%b, want 0 1", obs_hrdata, obs_ready);
    end
    n_cmp++;
    if (ram_writes != writes_before || ram[12'h080] !== old_word) begin
      n_bad++;
      $display("FAIL rst_mid_discard: writes %0d->%0d word=%h, want no write and %h",
               writes_before, ram_writes, ram[12'h080], old_word);
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_merge_word();
    test_merge_byte();
    test_back_to_back();
    test_random();
`ifdef AHB_TO_RAM_ERR_EN
    test_error();
`endif
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
